// File: rtl/secuenciador_configuracion_pkg.sv
// rtl/secuenciador_configuracion_pkg.sv - shared mode encodings, cursor limits and counter-select codes
package secuenciador_configuracion_pkg;

    // Mode encoding is driven unchanged on config_mode
    typedef enum logic [1:0] {
        MODO_NORMAL = 2'd0,
        MODO_HORA   = 2'd1,
        MODO_FECHA  = 2'd2,
        MODO_TIMER  = 2'd3
    } modo_t;

    // Highest selectable field per mode
    localparam logic [1:0] LIMITE_NORMAL = 2'd0;
    localparam logic [1:0] LIMITE_HORA   = 2'd2;
    localparam logic [1:0] LIMITE_FECHA  = 2'd3;
    localparam logic [1:0] LIMITE_TIMER  = 2'd2;

    // Counter-select codes: first code of each mode, field index is added on top
    localparam logic [3:0] EN_NINGUNO    = 4'd0;
    localparam logic [3:0] EN_HORA_BASE  = 4'd1;
    localparam logic [3:0] EN_FECHA_BASE = 4'd4;
    localparam logic [3:0] EN_TIMER_BASE = 4'd8;

    function automatic logic [1:0] limite_cursor(input modo_t modo);
        logic [1:0] limite;
        case (modo)
            MODO_HORA:  limite = LIMITE_HORA;
            MODO_FECHA: limite = LIMITE_FECHA;
            MODO_TIMER: limite = LIMITE_TIMER;
            default:    limite = LIMITE_NORMAL;
        endcase
        return limite;
    endfunction

    // Out-of-range cursors select nothing rather than aliasing into another mode
    function automatic logic [3:0] codigo_contador(input modo_t modo, input logic [1:0] cursor);
        logic [3:0] base;
        case (modo)
            MODO_HORA:  base = EN_HORA_BASE;
            MODO_FECHA: base = EN_FECHA_BASE;
            MODO_TIMER: base = EN_TIMER_BASE;
            default:    base = EN_NINGUNO;
        endcase
        if (modo == MODO_NORMAL || cursor > limite_cursor(modo)) begin
            return EN_NINGUNO;
        end
        return base + {2'b00, cursor};
    endfunction

endpackage

// File: rtl/secuenciador_configuracion_detector_flanco.sv
// rtl/secuenciador_configuracion_detector_flanco.sv - rising-edge detector, one tick per press
module detector_flanco (
    input  logic clk,
    input  logic reset,
    input  logic in_i,
    output logic tick_o
);

    logic prev_q;

    // Previous level clears in reset so a button held through release still ticks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= in_i;
        end
    end

    assign tick_o = in_i & ~prev_q;

endmodule

// File: rtl/secuenciador_configuracion.sv
// rtl/secuenciador_configuracion.sv - button-driven configuration mode sequencer
module secuenciador_configuracion
    import secuenciador_configuracion_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000_000,
    parameter int          TW             = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] config_mode,
    output logic [1:0] cursor_location,
    output logic [3:0] enable_counters,
    output logic       enUP,
    output logic       enDOWN,
    output logic       commit,
    output logic [1:0] commit_mode
);

    localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES - 32'd1);

    logic tick_mode, tick_left, tick_right, tick_up, tick_down;
    logic any_tick;

    detector_flanco u_det_mode  (.clk(clk), .reset(reset), .in_i(btn_mode),  .tick_o(tick_mode));
    detector_flanco u_det_left  (.clk(clk), .reset(reset), .in_i(btn_left),  .tick_o(tick_left));
    detector_flanco u_det_right (.clk(clk), .reset(reset), .in_i(btn_right), .tick_o(tick_right));
    detector_flanco u_det_up    (.clk(clk), .reset(reset), .in_i(btn_up),    .tick_o(tick_up));
    detector_flanco u_det_down  (.clk(clk), .reset(reset), .in_i(btn_down),  .tick_o(tick_down));

    assign any_tick = tick_mode | tick_left | tick_right | tick_up | tick_down;

    modo_t         state_q, state_d;
    logic [1:0]    cursor_q, cursor_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [3:0]    enc_q, enc_d;
    logic          en_up_q, en_up_d;
    logic          en_down_q, en_down_d;
    logic          commit_q, commit_d;
    logic [1:0]    commit_mode_q, commit_mode_d;
    logic [1:0]    limite;

    // Next state: one action per cycle, mode > left > right > up/down > idle timeout
    always_comb begin
        state_d       = state_q;
        cursor_d      = cursor_q;
        en_up_d       = 1'b0;
        en_down_d     = 1'b0;
        commit_d      = 1'b0;
        commit_mode_d = 2'd0;
        limite        = limite_cursor(state_q);

        if (tick_mode) begin
            cursor_d = 2'd0;
            case (state_q)
                MODO_NORMAL: state_d = MODO_HORA;
                MODO_HORA:   state_d = MODO_FECHA;
                MODO_FECHA:  state_d = MODO_TIMER;
                default: begin
                    state_d       = MODO_NORMAL;
                    commit_d      = 1'b1;
                    commit_mode_d = state_q;
                end
            endcase
        end else if (state_q == MODO_NORMAL) begin
            cursor_d = 2'd0;
        end else if (tick_left) begin
            cursor_d = (cursor_q >= limite) ? 2'd0 : cursor_q + 2'd1;
        end else if (tick_right) begin
            cursor_d = (cursor_q == 2'd0) ? limite : cursor_q - 2'd1;
        end else if (tick_up || tick_down) begin
            // Opposing presses in the same cycle cancel out
            en_up_d   = tick_up & ~tick_down;
            en_down_d = tick_down & ~tick_up;
        end else if (idle_q == IDLE_MAX) begin
            state_d       = MODO_NORMAL;
            cursor_d      = 2'd0;
            commit_d      = 1'b1;
            commit_mode_d = state_q;
        end

        if (any_tick || state_q == MODO_NORMAL) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
        end else begin
            idle_d = idle_q;
        end

        // Select code follows the registered mode/cursor so all outputs move together
        enc_d = codigo_contador(state_d, cursor_d);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= MODO_NORMAL;
            cursor_q      <= 2'd0;
            idle_q        <= '0;
            enc_q         <= EN_NINGUNO;
            en_up_q       <= 1'b0;
            en_down_q     <= 1'b0;
            commit_q      <= 1'b0;
            commit_mode_q <= 2'd0;
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            idle_q        <= idle_d;
            enc_q         <= enc_d;
            en_up_q       <= en_up_d;
            en_down_q     <= en_down_d;
            commit_q      <= commit_d;
            commit_mode_q <= commit_mode_d;
        end
    end

    assign config_mode     = state_q;
    assign cursor_location = cursor_q;
    assign enable_counters = enc_q;
    assign enUP            = en_up_q;
    assign enDOWN          = en_down_q;
    assign commit          = commit_q;
    assign commit_mode     = commit_mode_q;

endmodule

// File: tb/tb_secuenciador_configuracion.sv
// tb/tb_secuenciador_configuracion.sv - directed self-checking bench for secuenciador_configuracion
module tb_secuenciador_configuracion;

    localparam logic [4:0] B_MODE  = 5'b10000;
    localparam logic [4:0] B_LEFT  = 5'b01000;
    localparam logic [4:0] B_RIGHT = 5'b00100;
    localparam logic [4:0] B_UP    = 5'b00010;
    localparam logic [4:0] B_DOWN  = 5'b00001;

    logic       clk;
    logic       rst_n;
    logic [4:0] btns;
    logic [1:0] config_mode;
    logic [1:0] cursor_location;
    logic [3:0] enable_counters;
    logic       en_up;
    logic       en_down;
    logic       commit;
    logic [1:0] commit_mode;

    int passed = 0;
    int total  = 0;
    int pulses;

    secuenciador_configuracion #(
        .TIMEOUT_CYCLES(32'd16),
        .TW            (5)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .btn_mode       (btns[4]),
        .btn_left       (btns[3]),
        .btn_right      (btns[2]),
        .btn_up         (btns[1]),
        .btn_down       (btns[0]),
        .config_mode    (config_mode),
        .cursor_location(cursor_location),
        .enable_counters(enable_counters),
        .enUP           (en_up),
        .enDOWN         (en_down),
        .commit         (commit),
        .commit_mode    (commit_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tap(input logic [4:0] b);
        btns = b;
        step();
    endtask

    task automatic rel();
        btns = 5'b0;
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " config_mode"}, 32'(config_mode), 0);
        chk({tag, " cursor"}, 32'(cursor_location), 0);
        chk({tag, " enable_counters"}, 32'(enable_counters), 0);
        chk({tag, " enUP"}, 32'(en_up), 0);
        chk({tag, " enDOWN"}, 32'(en_down), 0);
        chk({tag, " commit"}, 32'(commit), 0);
        chk({tag, " commit_mode"}, 32'(commit_mode), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        btns  = 5'b0;
        #12;
        chk_all_zero("reset");
        step();
        rst_n = 1'b1;
        step();

        // Mode cycling, commit only when leaving TIMER
        tap(B_MODE);
        chk("m1 mode", 32'(config_mode), 1);
        chk("m1 enc", 32'(enable_counters), 1);
        chk("m1 commit", 32'(commit), 0);
        rel();
        tap(B_MODE);
        chk("m2 mode", 32'(config_mode), 2);
        chk("m2 enc", 32'(enable_counters), 4);
        chk("m2 commit", 32'(commit), 0);
        rel();
        tap(B_MODE);
        chk("m3 mode", 32'(config_mode), 3);
        chk("m3 enc", 32'(enable_counters), 8);
        chk("m3 commit", 32'(commit), 0);
        rel();
        tap(B_MODE);
        chk("m4 mode", 32'(config_mode), 0);
        chk("m4 enc", 32'(enable_counters), 0);
        chk("m4 commit", 32'(commit), 1);
        chk("m4 commit_mode", 32'(commit_mode), 3);
        rel();
        chk("m4 commit drop", 32'(commit), 0);
        chk("m4 commit_mode drop", 32'(commit_mode), 0);

        // NORMAL ignores navigation and up/down
        tap(B_LEFT);
        chk("normal left cursor", 32'(cursor_location), 0);
        rel();
        tap(B_UP);
        chk("normal up enUP", 32'(en_up), 0);
        chk("normal up mode", 32'(config_mode), 0);
        rel();

        // FECHA cursor wrap
        tap(B_MODE); rel();
        tap(B_MODE); rel();
        chk("fecha mode", 32'(config_mode), 2);
        chk("fecha cursor0", 32'(cursor_location), 0);
        tap(B_RIGHT);
        chk("fecha right cursor", 32'(cursor_location), 3);
        chk("fecha right enc", 32'(enable_counters), 7);
        rel();
        tap(B_LEFT);
        chk("fecha left1 cursor", 32'(cursor_location), 0);
        rel();
        tap(B_LEFT);
        chk("fecha left2 cursor", 32'(cursor_location), 1);
        chk("fecha left2 enc", 32'(enable_counters), 5);
        rel();
        tap(B_MODE);
        chk("timer from fecha cursor", 32'(cursor_location), 0);
        chk("timer from fecha commit", 32'(commit), 0);
        rel();
        tap(B_MODE);
        chk("exit timer commit", 32'(commit), 1);
        chk("exit timer commit_mode", 32'(commit_mode), 3);
        rel();

        // HORA up/down pulses
        tap(B_MODE); rel();
        tap(B_RIGHT);
        chk("hora right cursor", 32'(cursor_location), 2);
        chk("hora right enc", 32'(enable_counters), 3);
        rel();
        btns = B_UP;
        step();
        chk("hold up first enUP", 32'(en_up), 1);
        chk("hold up first enDOWN", 32'(en_down), 0);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (en_up) pulses++;
        end
        chk("hold up extra pulses", 32'(pulses), 0);
        rel();
        btns = B_UP | B_DOWN;
        step();
        chk("up+down enUP", 32'(en_up), 0);
        chk("up+down enDOWN", 32'(en_down), 0);
        rel();
        tap(B_DOWN);
        chk("down enDOWN", 32'(en_down), 1);
        chk("down enUP", 32'(en_up), 0);
        rel();
        chk("down drop", 32'(en_down), 0);

        // Mode beats left in the same cycle
        tap(B_RIGHT);
        chk("hora cursor1", 32'(cursor_location), 1);
        rel();
        tap(B_MODE | B_LEFT);
        chk("mode+left mode", 32'(config_mode), 2);
        chk("mode+left cursor", 32'(cursor_location), 0);
        rel();

        // Idle timeout in TIMER, tick at the last count wins
        tap(B_MODE);
        chk("to timer mode", 32'(config_mode), 3);
        btns = 5'b0;
        repeat (15) step();
        chk("idle15 mode", 32'(config_mode), 3);
        tap(B_UP);
        chk("tick at 15 mode", 32'(config_mode), 3);
        chk("tick at 15 enUP", 32'(en_up), 1);
        btns = 5'b0;
        repeat (15) step();
        chk("idle15b mode", 32'(config_mode), 3);
        chk("idle15b commit", 32'(commit), 0);
        step();
        chk("timeout mode", 32'(config_mode), 0);
        chk("timeout commit", 32'(commit), 1);
        chk("timeout commit_mode", 32'(commit_mode), 3);
        step();
        chk("timeout commit drop", 32'(commit), 0);

        // Asynchronous reset mid-session, button held through release
        tap(B_MODE); rel();
        tap(B_MODE); rel();
        tap(B_MODE); rel();
        tap(B_LEFT);
        chk("pre-reset enc", 32'(enable_counters), 9);
        rel();
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        btns = B_MODE;
        step();
        chk("in reset commit", 32'(commit), 0);
        chk("in reset mode", 32'(config_mode), 0);
        rst_n = 1'b1;
        step();
        chk("held through reset mode", 32'(config_mode), 1);
        chk("held through reset commit", 32'(commit), 0);
        rel();
        step();
        chk("no retick mode", 32'(config_mode), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
